// File: rtl/asi_pkg.sv
// Shared types for the user-side memory endpoint behind the AXI slave.
package asi_pkg;

    typedef enum logic {MEM_INIT, MEM_RUN} TYPE_MEM_ST;

    localparam int ASI_MEM_MAX_WS = 8;

endpackage

// File: rtl/asi_rd_pipe.sv
// Read-return delay line; a stage only reloads when a result passes through,
// so the last stage keeps presenting the most recent result.
module asi_rd_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         usr_clk,
    input  logic         usr_reset_n,
    input  logic         in_v,
    input  logic [W-1:0] in_d,
    output logic [W-1:0] out_d
);

    logic [DEPTH-1:0] ld;
    logic [W-1:0]     d_q [DEPTH];

    assign ld[0] = in_v;

    if (DEPTH > 1) begin : g_vld
        logic [DEPTH-2:0] v_q;

        always_ff @(posedge usr_clk or negedge usr_reset_n) begin
            if (!usr_reset_n) v_q <= '0;
            else              v_q <= ld[DEPTH-2:0];
        end

        assign ld[DEPTH-1:1] = v_q;
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
        end else begin
            if (ld[0]) d_q[0] <= in_d;
            for (int k = 1; k < DEPTH; k++)
                if (ld[k]) d_q[k] <= d_q[k-1];
        end
    end

    assign out_d = d_q[DEPTH-1];

endmodule

// File: rtl/asi_usr_mem.sv
// Byte-strobed word memory on the user strobe bus, with post-reset clear,
// range checking, fixed-latency read return and sticky error/statistics.
module asi_usr_mem
    import asi_pkg::*;
#(
    parameter int              AXI_DW     = 128,
    parameter int              AXI_AW     = 40,
    parameter int              AXI_WSTRBW = AXI_DW / 8,
    parameter int              MEM_DEPTH  = 1024,
    parameter longint unsigned BASE_ADDR  = 0,
    parameter int              SLV_WS     = 2,
    parameter int              INIT_ZERO  = 1,
    parameter int              CNT_W      = 32
) (
    input  logic                  usr_clk,
    input  logic                  usr_reset_n,
    input  logic [AXI_AW-1:0]     m_addr,
    input  logic [AXI_DW-1:0]     m_wdata,
    input  logic [AXI_WSTRBW-1:0] m_wstrb,
    input  logic                  m_we,
    input  logic                  m_re,
    output logic [AXI_DW-1:0]     m_rdata,
    output logic                  m_rerr,
    output logic                  init_done,
    output logic                  err_sticky,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      rd_cnt
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int BW = $clog2(AXI_WSTRBW);

    localparam logic [AXI_AW:0] LO   = (AXI_AW+1)'(BASE_ADDR);
    localparam logic [AXI_AW:0] SPAN = (AXI_AW+1)'(MEM_DEPTH * AXI_WSTRBW);

    TYPE_MEM_ST st_q, st_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;

    logic [AXI_AW:0] off;
    logic [IW-1:0]   idx;
    logic            in_range;
    logic            acc_ok;
    logic            wr_ok;
    logic            rd_ok;
    logic            err_ev;

    logic [AXI_DW-1:0]     mem [MEM_DEPTH];
    logic                  mem_we;
    logic [IW-1:0]         mem_idx;
    logic [AXI_WSTRBW-1:0] mem_be;
    logic [AXI_DW-1:0]     mem_wd;

    logic [AXI_DW:0] rd_res;

    // One extra bit so addresses below the base land far above SPAN.
    assign off      = {1'b0, m_addr} - LO;
    assign in_range = (off < SPAN);
    assign idx      = off[BW +: IW];

    assign acc_ok = init_done && in_range;
    assign wr_ok  = m_we && acc_ok;
    assign rd_ok  = m_re && acc_ok;
    assign err_ev = ((m_we || m_re) && !acc_ok) || (m_we && m_re);

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            st_q      <= MEM_INIT;
            clr_idx_q <= '0;
        end else begin
            st_q      <= st_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        clr_idx_d = clr_idx_q;
        mem_we    = wr_ok;
        mem_idx   = idx;
        mem_be    = m_wstrb;
        mem_wd    = m_wdata;
        unique case (st_q)
            MEM_INIT: begin
                if (INIT_ZERO != 0) begin
                    mem_we    = 1'b1;
                    mem_idx   = clr_idx_q;
                    mem_be    = '1;
                    mem_wd    = '0;
                    clr_idx_d = clr_idx_q + 1'b1;
                    if (clr_idx_q == IW'(MEM_DEPTH - 1))
                        st_d = MEM_RUN;
                end else begin
                    st_d = MEM_RUN;
                end
            end
            MEM_RUN: ;
            default: st_d = MEM_INIT;
        endcase
    end

    // Single byte-enabled write port shared by the clear and user writes.
    always_ff @(posedge usr_clk) begin
        if (mem_we)
            for (int b = 0; b < AXI_WSTRBW; b++)
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            init_done  <= 1'b0;
            err_sticky <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            init_done <= (INIT_ZERO == 0) || (st_q == MEM_RUN);
            if (err_ev)       err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
            if (wr_ok && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            if (rd_ok && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // A colliding write still shows the pre-write word, flagged as an error.
    assign rd_res = acc_ok ? {m_we, mem[idx]} : {1'b1, {AXI_DW{1'b0}}};

    if (SLV_WS == 0) begin : g_ws0
        logic [AXI_DW:0] hold_q;

        always_ff @(posedge usr_clk or negedge usr_reset_n) begin
            if (!usr_reset_n) hold_q <= '0;
            else if (m_re)    hold_q <= rd_res;
        end

        assign {m_rerr, m_rdata} = m_re ? rd_res : hold_q;
    end else if (SLV_WS == 1) begin : g_ws1
        always_ff @(posedge usr_clk or negedge usr_reset_n) begin
            if (!usr_reset_n) {m_rerr, m_rdata} <= '0;
            else if (m_re)    {m_rerr, m_rdata} <= rd_res;
        end
    end else begin : g_wsn
        logic            s1_v;
        logic [AXI_DW:0] s1_q;
        logic [AXI_DW:0] pipe_q;

        always_ff @(posedge usr_clk or negedge usr_reset_n) begin
            if (!usr_reset_n) begin
                s1_v <= 1'b0;
                s1_q <= '0;
            end else begin
                s1_v <= m_re;
                if (m_re) s1_q <= rd_res;
            end
        end

        asi_rd_pipe #(
            .W     (AXI_DW + 1),
            .DEPTH (SLV_WS - 1)
        ) u_rd_pipe (
            .usr_clk     (usr_clk),
            .usr_reset_n (usr_reset_n),
            .in_v        (s1_v),
            .in_d        (s1_q),
            .out_d       (pipe_q)
        );

        assign {m_rerr, m_rdata} = pipe_q;
    end

endmodule

// File: tb/tb_asi_usr_mem.sv
// Scoreboard bench: four endpoints (read latency 0..3) share one stimulus stream
// and are checked against a word-array reference model.
module tb_asi_usr_mem;

    localparam int              DW    = 128;
    localparam int              AW    = 40;
    localparam int              SW    = 16;
    localparam int              DEPTH = 16;
    localparam int              CW    = 6;
    localparam int              NDUT  = 4;
    localparam longint unsigned BASE  = 64'h1000;
    localparam longint unsigned SPAN  = DEPTH * SW;

    typedef struct packed {
        logic          rerr;
        logic [DW-1:0] data;
    } exp_t;

    logic          usr_clk     = 1'b0;
    logic          usr_reset_n = 1'b1;
    logic [AW-1:0] m_addr      = '0;
    logic [DW-1:0] m_wdata     = '0;
    logic [SW-1:0] m_wstrb     = '0;
    logic          m_we        = 1'b0;
    logic          m_re        = 1'b0;
    logic          err_clr     = 1'b0;

    logic [DW-1:0] rdata   [NDUT];
    logic          rerr    [NDUT];
    logic          idone   [NDUT];
    logic          esticky [NDUT];
    logic [CW-1:0] wrc     [NDUT];
    logic [CW-1:0] rdc     [NDUT];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [DEPTH];
    int            cyc = 0;
    logic [CW-1:0] wr_m = '0;
    logic [CW-1:0] rd_m = '0;
    bit            sticky_m = 1'b0;

    exp_t     exp_l[$];
    int       rd_ptr [NDUT];
    exp_t     last   [NDUT];
    logic [3:0] hist = '0;

    always #5 usr_clk = ~usr_clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        asi_usr_mem #(
            .AXI_DW    (DW),
            .AXI_AW    (AW),
            .MEM_DEPTH (DEPTH),
            .BASE_ADDR (BASE),
            .SLV_WS    (g),
            .INIT_ZERO (1),
            .CNT_W     (CW)
        ) u_dut (
            .usr_clk     (usr_clk),
            .usr_reset_n (usr_reset_n),
            .m_addr      (m_addr),
            .m_wdata     (m_wdata),
            .m_wstrb     (m_wstrb),
            .m_we        (m_we),
            .m_re        (m_re),
            .m_rdata     (rdata[g]),
            .m_rerr      (rerr[g]),
            .init_done   (idone[g]),
            .err_sticky  (esticky[g]),
            .err_clr     (err_clr),
            .wr_cnt      (wrc[g]),
            .rd_cnt      (rdc[g])
        );
    end

    task automatic chk(input string name, input logic [DW:0] act,
                       input logic [DW:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: whole-transaction rules, evaluated when issued.
    task automatic step(input bit we, input bit re, input bit clr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] be);
        bit   acc, inr;
        int   idx;
        exp_t e;
        m_we = we; m_re = re; err_clr = clr;
        m_addr = a; m_wdata = wd; m_wstrb = be;
        acc = (cyc >= DEPTH + 1);
        inr = (64'(a) >= BASE) && (64'(a) < BASE + SPAN);
        idx = inr ? int'((64'(a) - BASE) / SW) : 0;
        if (re) begin
            e.rerr = !(acc && inr) || we;
            e.data = (acc && inr) ? mdl[idx] : '0;
            exp_l.push_back(e);
        end
        if (((we || re) && !(acc && inr)) || (we && re)) sticky_m = 1'b1;
        else if (clr)                                   sticky_m = 1'b0;
        if (we && acc && inr) begin
            for (int b = 0; b < SW; b++)
                if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
            if (wr_m != '1) wr_m++;
        end
        if (re && acc && inr && rd_m != '1) rd_m++;
        @(posedge usr_clk);
        #1;
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("init_done[%0d] cyc%0d", d, cyc),
                (DW+1)'(idone[d]), (DW+1)'(cyc >= DEPTH + 1));
            chk($sformatf("err_sticky[%0d] cyc%0d", d, cyc),
                (DW+1)'(esticky[d]), (DW+1)'(sticky_m));
            chk($sformatf("wr_cnt[%0d] cyc%0d", d, cyc),
                (DW+1)'(wrc[d]), (DW+1)'(wr_m));
            chk($sformatf("rd_cnt[%0d] cyc%0d", d, cyc),
                (DW+1)'(rdc[d]), (DW+1)'(rd_m));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, m_addr, '0, '0);
    endtask

    task automatic do_reset(input int n);
        m_we = 1'b0; m_re = 1'b0; err_clr = 1'b0;
        usr_reset_n = 1'b0;
        repeat (n) @(posedge usr_clk);
        #1;
        usr_reset_n = 1'b1;
        cyc = 0; wr_m = '0; rd_m = '0; sticky_m = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    function automatic logic [AW-1:0] wa(input int w, input int lo);
        return AW'(BASE + longint'(w * SW + lo));
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)       return AW'(BASE + longint'($urandom_range(0, 255)));
        else if (r == 8) return AW'(BASE + SPAN + longint'($urandom_range(0, 4095)));
        else             return AW'($urandom_range(0, 4095));
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: tracks its own delayed m_re and consumes expected results.
    always @(negedge usr_clk) begin
        if (!usr_reset_n) begin
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("rst_rdata[%0d]", d), {rerr[d], rdata[d]}, '0);
                chk($sformatf("rst_stat[%0d]", d),
                    (DW+1)'({idone[d], esticky[d], wrc[d], rdc[d]}), '0);
                rd_ptr[d] = 0;
                last[d]   = '0;
            end
            exp_l.delete();
            hist = '0;
        end else begin
            hist = {hist[2:0], m_re};
            for (int d = 0; d < NDUT; d++) begin
                if (hist[d]) begin
                    if (rd_ptr[d] >= exp_l.size()) begin
                        total++; bad++;
                        $display("FAIL rd_underflow[%0d]: got result, want none", d);
                    end else begin
                        chk($sformatf("rdata[%0d] n%0d", d, rd_ptr[d]),
                            {rerr[d], rdata[d]}, exp_l[rd_ptr[d]]);
                        last[d] = exp_l[rd_ptr[d]];
                        rd_ptr[d]++;
                    end
                end else begin
                    chk($sformatf("hold[%0d]", d), {rerr[d], rdata[d]}, last[d]);
                end
            end
            while (exp_l.size() > 0 && rd_ptr[0] > 0 && rd_ptr[1] > 0 &&
                   rd_ptr[2] > 0 && rd_ptr[3] > 0) begin
                void'(exp_l.pop_front());
                for (int d = 0; d < NDUT; d++) rd_ptr[d]--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  op;
        bit  we, re;
        for (int d = 0; d < NDUT; d++) begin
            rd_ptr[d] = 0;
            last[d]   = '0;
        end
        #1;
        do_reset(3);

        // Accesses during the clear, including an error colliding with err_clr.
        idle(2);
        step(1, 0, 0, wa(2, 0), rnd_data(), '1);
        step(0, 1, 0, wa(2, 0), '0, '0);
        step(1, 1, 1, wa(4, 3), rnd_data(), '1);
        step(0, 0, 1, m_addr, '0, '0);
        step(1, 1, 0, wa(5, 0), rnd_data(), '1);
        while (cyc < DEPTH + 1) idle(1);
        step(0, 0, 1, m_addr, '0, '0);

        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 0, wa(i, i % SW), '0, '0);

        step(1, 0, 0, wa(1, 0), {SW{8'hA5}}, 16'h00FF);
        step(0, 1, 0, wa(1, 0), '0, '0);
        idle(4);

        step(1, 0, 0, wa(2, 0), rnd_data(), '1);
        for (int i = 0; i < 9; i++)
            step(0, 1, 0, wa(i % 3, 0), '0, '0);
        idle(2);

        step(1, 0, 0, AW'(BASE + SPAN), rnd_data(), '1);
        step(0, 1, 0, AW'(BASE + SPAN), '0, '0);
        step(0, 1, 0, AW'(BASE - 1), '0, '0);
        step(0, 0, 1, m_addr, '0, '0);
        step(1, 0, 0, wa(3, 0), rnd_data(), '0);
        step(0, 1, 0, wa(3, 0), '0, '0);

        step(1, 1, 0, wa(3, 0), rnd_data(), 16'hF0F0);
        step(0, 1, 0, wa(3, 0), '0, '0);
        step(0, 1, 1, AW'(BASE + SPAN + 64'h10), '0, '0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 99);
            we = (op < 45) || (op >= 95);
            re = (op >= 45 && op < 90) || (op >= 95);
            step(we, re, $urandom_range(0, 15) == 0, rnd_addr(), rnd_data(),
                 SW'($urandom));
        end
        idle(4);

        // Reset with reads in flight: pipeline flushed, clear restarts.
        step(0, 1, 0, wa(1, 0), '0, '0);
        step(0, 1, 0, wa(3, 0), '0, '0);
        do_reset(2);
        idle(3);
        step(0, 1, 0, wa(1, 0), '0, '0);
        while (cyc < DEPTH + 1) idle(1);
        step(0, 1, 0, wa(1, 0), '0, '0);
        for (int i = 0; i < 80; i++)
            step(1, 0, 0, wa(i % DEPTH, 0), rnd_data(), SW'($urandom));
        step(0, 1, 0, wa(7, 0), '0, '0);
        idle(5);

        chk("drain", (DW+1)'(exp_l.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
